multi_cycle_ctrl: RTL and testbench

//  Multi-cycle successor to the single-cycle control unit: a Moore FSM that sequences

---
 rtl/mcc_pkg.sv | 79 +++++++
 rtl/multi_cycle_ctrl_alu_func_decode.sv | 43 ++++
 rtl/multi_cycle_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mcc_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: states, opcode/func fields,
// ALU operation codes and datapath mux selects.
package mcc_pkg;

   typedef enum logic [3:0] {
      StIf    = 4'd0,
      StId    = 4'd1,
      StExR   = 4'd2,
      StExI   = 4'd3,
      StExMa  = 4'd4,
      StExBr  = 4'd5,
      StExJ   = 4'd6,
      StMemRd = 4'd7,
      StMemWr = 4'd8,
      StWbR   = 4'd9,
      StWbI   = 4'd10,
      StWbMem = 4'd11
   } mcc_state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;

   localparam logic [5:0] FN_SLL  = 6'b000000;
   localparam logic [5:0] FN_SRL  = 6'b000010;
   localparam logic [5:0] FN_SRA  = 6'b000011;
   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_ADDU = 6'b100001;
   localparam logic [5:0] FN_SUB  = 6'b100010;
   localparam logic [5:0] FN_SUBU = 6'b100011;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_XOR  = 6'b100110;
   localparam logic [5:0] FN_NOR  = 6'b100111;
   localparam logic [5:0] FN_SLT  = 6'b101010;
   localparam logic [5:0] FN_SLTU = 6'b101011;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_NOR  = 4'd5;
   localparam logic [3:0] ALU_SLT  = 4'd6;
   localparam logic [3:0] ALU_SLTU = 4'd7;
   localparam logic [3:0] ALU_SLL  = 4'd8;
   localparam logic [3:0] ALU_SRL  = 4'd9;
   localparam logic [3:0] ALU_SRA  = 4'd10;
   localparam logic [3:0] ALU_LUI  = 4'd11;

   localparam logic [1:0] SRCB_B      = 2'd0;
   localparam logic [1:0] SRCB_FOUR   = 2'd1;
   localparam logic [1:0] SRCB_IMM    = 2'd2;
   localparam logic [1:0] SRCB_IMM_SH = 2'd3;

   localparam logic [1:0] PCSRC_ALU    = 2'd0;
   localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
   localparam logic [1:0] PCSRC_JUMP   = 2'd2;

   function automatic logic [3:0] imm_alu_ctr(input logic [5:0] op);
      case (op)
         OP_SLTI: return ALU_SLT;
         OP_ANDI: return ALU_AND;
         OP_ORI:  return ALU_OR;
         OP_LUI:  return ALU_LUI;
         default: return ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/multi_cycle_ctrl_alu_func_decode.sv
// R-type function field decoder: ALU operation, shamt select and legality of func.
module alu_func_decode
   import mcc_pkg::*;
#(
   parameter int unsigned FUNC_W   = 6,
   parameter int unsigned ALUCTR_W = 4
) (
   input  logic [FUNC_W-1:0]   i_func,
   output logic [ALUCTR_W-1:0] o_alu_ctr,
   output logic                o_shift,
   output logic                o_func_valid
);

   always_comb begin
      o_alu_ctr    = ALU_ADD;
      o_shift      = 1'b0;
      o_func_valid = 1'b1;
      case (i_func)
         FN_ADD, FN_ADDU: o_alu_ctr = ALU_ADD;
         FN_SUB, FN_SUBU: o_alu_ctr = ALU_SUB;
         FN_AND:          o_alu_ctr = ALU_AND;
         FN_OR:           o_alu_ctr = ALU_OR;
         FN_XOR:          o_alu_ctr = ALU_XOR;
         FN_NOR:          o_alu_ctr = ALU_NOR;
         FN_SLT:          o_alu_ctr = ALU_SLT;
         FN_SLTU:         o_alu_ctr = ALU_SLTU;
         FN_SLL: begin
            o_alu_ctr = ALU_SLL;
            o_shift   = 1'b1;
         end
         FN_SRL: begin
            o_alu_ctr = ALU_SRL;
            o_shift   = 1'b1;
         end
         FN_SRA: begin
            o_alu_ctr = ALU_SRA;
            o_shift   = 1'b1;
         end
         default: o_func_valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Moore-style multi-cycle MIPS control FSM (IF/ID/EX/MEM/WB).
// Define MCC_STALL_EN to add i_mem_ready and hold IF/MEM states until memory completes.
module multi_cycle_ctrl
   import mcc_pkg::*;
#(
   parameter int unsigned OP_W     = 6,
   parameter int unsigned FUNC_W   = 6,
   parameter int unsigned ALUCTR_W = 4
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [OP_W-1:0]     i_op,
   input  logic [FUNC_W-1:0]   i_func,
`ifdef MCC_STALL_EN
   input  logic                i_mem_ready,
`endif
   output logic                o_pc_wr,
   output logic                o_pc_wr_eq,
   output logic                o_pc_wr_ne,
   output logic [1:0]          o_pc_src,
   output logic                o_ir_wr,
   output logic                o_iord,
   output logic                o_mem_rd,
   output logic                o_mem_wr,
   output logic                o_reg_wr,
   output logic                o_reg_dst,
   output logic                o_mem_to_reg,
   output logic                o_alu_src_a,
   output logic [1:0]          o_alu_src_b,
   output logic [ALUCTR_W-1:0] o_alu_ctr,
   output logic                o_ext_op,
   output logic                o_shift,
   output logic                o_illegal,
   output logic [3:0]          o_state
);

   mcc_state_e r_state, w_state_nxt;

   logic                w_mem_ready;
   logic [ALUCTR_W-1:0] w_func_alu;
   logic                w_func_shift;
   logic                w_func_valid;
   logic                w_is_imm_alu;
   logic                w_is_logic_imm;

`ifdef MCC_STALL_EN
   assign w_mem_ready = i_mem_ready;
`else
   assign w_mem_ready = 1'b1;
`endif

   alu_func_decode #(
      .FUNC_W   (FUNC_W),
      .ALUCTR_W (ALUCTR_W)
   ) u_func_dec (
      .i_func       (i_func),
      .o_alu_ctr    (w_func_alu),
      .o_shift      (w_func_shift),
      .o_func_valid (w_func_valid)
   );

   assign w_is_logic_imm = (i_op == OP_ANDI) || (i_op == OP_ORI) || (i_op == OP_LUI);
   assign w_is_imm_alu   = w_is_logic_imm || (i_op == OP_ADDI) || (i_op == OP_ADDIU) ||
                           (i_op == OP_SLTI);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= StIf;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt  = r_state;
      o_pc_wr      = 1'b0;
      o_pc_wr_eq   = 1'b0;
      o_pc_wr_ne   = 1'b0;
      o_pc_src     = PCSRC_ALU;
      o_ir_wr      = 1'b0;
      o_iord       = 1'b0;
      o_mem_rd     = 1'b0;
      o_mem_wr     = 1'b0;
      o_reg_wr     = 1'b0;
      o_reg_dst    = 1'b0;
      o_mem_to_reg = 1'b0;
      o_alu_src_a  = 1'b0;
      o_alu_src_b  = SRCB_B;
      o_alu_ctr    = ALU_ADD;
      o_ext_op     = 1'b1;
      o_shift      = 1'b0;
      o_illegal    = 1'b0;
      case (r_state)
         StIf: begin
            o_mem_rd    = 1'b1;
            o_alu_src_b = SRCB_FOUR;
            if (w_mem_ready) begin
               o_ir_wr     = 1'b1;
               o_pc_wr     = 1'b1;
               w_state_nxt = StId;
            end
         end
         StId: begin
            o_alu_src_b = SRCB_IMM_SH;
            w_state_nxt = StIf;
            if (i_op == OP_RTYPE) begin
               if (w_func_valid) w_state_nxt = StExR;
               else              o_illegal   = 1'b1;
            end else if (i_op == OP_LW || i_op == OP_SW) begin
               w_state_nxt = StExMa;
            end else if (i_op == OP_BEQ || i_op == OP_BNE) begin
               w_state_nxt = StExBr;
            end else if (i_op == OP_J) begin
               w_state_nxt = StExJ;
            end else if (w_is_imm_alu) begin
               w_state_nxt = StExI;
            end else begin
               o_illegal = 1'b1;
            end
         end
         StExR: begin
            o_alu_src_a = 1'b1;
            o_alu_ctr   = w_func_alu;
            o_shift     = w_func_shift;
            w_state_nxt = StWbR;
         end
         StExI: begin
            o_alu_src_a = 1'b1;
            o_alu_src_b = SRCB_IMM;
            o_alu_ctr   = imm_alu_ctr(i_op);
            o_ext_op    = ~w_is_logic_imm;
            w_state_nxt = StWbI;
         end
         StExMa: begin
            o_alu_src_a = 1'b1;
            o_alu_src_b = SRCB_IMM;
            w_state_nxt = (i_op == OP_LW) ? StMemRd : StMemWr;
         end
         StExBr: begin
            o_alu_src_a = 1'b1;
            o_alu_ctr   = ALU_SUB;
            o_pc_src    = PCSRC_ALUOUT;
            o_pc_wr_eq  = (i_op == OP_BEQ);
            o_pc_wr_ne  = (i_op == OP_BNE);
            w_state_nxt = StIf;
         end
         StExJ: begin
            o_pc_src    = PCSRC_JUMP;
            o_pc_wr     = 1'b1;
            w_state_nxt = StIf;
         end
         StMemRd: begin
            o_iord   = 1'b1;
            o_mem_rd = 1'b1;
            if (w_mem_ready) w_state_nxt = StWbMem;
         end
         StMemWr: begin
            o_iord   = 1'b1;
            o_mem_wr = 1'b1;
            if (w_mem_ready) w_state_nxt = StIf;
         end
         StWbR: begin
            o_reg_wr    = 1'b1;
            o_reg_dst   = 1'b1;
            w_state_nxt = StIf;
         end
         StWbI: begin
            o_reg_wr    = 1'b1;
            w_state_nxt = StIf;
         end
         StWbMem: begin
            o_reg_wr     = 1'b1;
            o_mem_to_reg = 1'b1;
            w_state_nxt  = StIf;
         end
         default: w_state_nxt = StIf;
      endcase
      // Reset is asynchronous, so strobes must drop combinationally, not on the next edge.
      if (i_rst) begin
         o_pc_wr    = 1'b0;
         o_pc_wr_eq = 1'b0;
         o_pc_wr_ne = 1'b0;
         o_ir_wr    = 1'b0;
         o_mem_wr   = 1'b0;
         o_reg_wr   = 1'b0;
         o_illegal  = 1'b0;
      end
   end

   assign o_state = r_state;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Randomized self-checking bench for multi_cycle_ctrl against a per-instruction phase model.
module tb_multi_cycle_ctrl;
   import mcc_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] op;
   logic [5:0] func;
   logic       mem_ready;

   logic       pc_wr, pc_wr_eq, pc_wr_ne, ir_wr, iord, mem_rd, mem_wr, reg_wr;
   logic       reg_dst, mem_to_reg, alu_src_a, ext_op, shift, illegal;
   logic [1:0] pc_src, alu_src_b;
   logic [3:0] alu_ctr, state;
   logic [21:0] obs;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   multi_cycle_ctrl dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_op         (op),
      .i_func       (func),
`ifdef MCC_STALL_EN
      .i_mem_ready  (mem_ready),
`endif
      .o_pc_wr      (pc_wr),
      .o_pc_wr_eq   (pc_wr_eq),
      .o_pc_wr_ne   (pc_wr_ne),
      .o_pc_src     (pc_src),
      .o_ir_wr      (ir_wr),
      .o_iord       (iord),
      .o_mem_rd     (mem_rd),
      .o_mem_wr     (mem_wr),
      .o_reg_wr     (reg_wr),
      .o_reg_dst    (reg_dst),
      .o_mem_to_reg (mem_to_reg),
      .o_alu_src_a  (alu_src_a),
      .o_alu_src_b  (alu_src_b),
      .o_alu_ctr    (alu_ctr),
      .o_ext_op     (ext_op),
      .o_shift      (shift),
      .o_illegal    (illegal),
      .o_state      (state)
   );

   assign obs = {pc_wr, pc_wr_eq, pc_wr_ne, pc_src, ir_wr, iord, mem_rd, mem_wr, reg_wr,
                 reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_ctr, ext_op, shift, illegal};

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h want 0x%0h (op=%b func=%b t=%0t)", tag, got, want, op,
                  func, $time);
      end
   endtask

   // R-type ALU op by func; -1 marks an undecodable func.
   function automatic int r_alu(input logic [5:0] f);
      case (f)
         6'b100000, 6'b100001: return 0;
         6'b100010, 6'b100011: return 1;
         6'b100100: return 2;
         6'b100101: return 3;
         6'b100110: return 4;
         6'b100111: return 5;
         6'b101010: return 6;
         6'b101011: return 7;
         6'b000000: return 8;
         6'b000010: return 9;
         6'b000011: return 10;
         default:   return -1;
      endcase
   endfunction

   function automatic int i_alu(input logic [5:0] o);
      case (o)
         6'b001000, 6'b001001: return 0;
         6'b001010: return 6;
         6'b001100: return 2;
         6'b001101: return 3;
         6'b001111: return 11;
         default:   return -1;
      endcase
   endfunction

   // Phase list of one instruction assuming zero memory wait.
   function automatic void build_seq(input logic [5:0] o, input logic [5:0] f,
                                     output mcc_state_e seq[$]);
      seq = {StIf, StId};
      if (o == 6'b000000) begin
         if (r_alu(f) >= 0) seq = {seq, StExR, StWbR};
      end else if (o == 6'b100011) seq = {seq, StExMa, StMemRd, StWbMem};
      else if (o == 6'b101011) seq = {seq, StExMa, StMemWr};
      else if (o == 6'b000100 || o == 6'b000101) seq = {seq, StExBr};
      else if (o == 6'b000010) seq = {seq, StExJ};
      else if (i_alu(o) >= 0) seq = {seq, StExI, StWbI};
   endfunction

   function automatic logic [21:0] exp_outs(input mcc_state_e st, input logic [5:0] o,
                                            input logic [5:0] f, input logic rdy);
      logic pw = 0, peq = 0, pne = 0, irw = 0, io = 0, mr = 0, mw = 0, rw = 0;
      logic rd = 0, m2r = 0, sa = 0, ext = 1, sh = 0, ill = 0;
      logic [1:0] ps = 0, sb = 0;
      logic [3:0] alu = 0;
      case (st)
         StIf: begin
            mr = 1; sb = 1;
            if (rdy) begin irw = 1; pw = 1; end
         end
         StId: begin
            sb = 3;
            ill = (o == 6'b000000) ? (r_alu(f) < 0) :
                  !(o inside {6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010}) &&
                  (i_alu(o) < 0);
         end
         StExR: begin
            sa = 1; alu = 4'(r_alu(f)); sh = (f == 6'b000000 || f == 6'b000010 || f == 6'b000011);
         end
         StExI: begin
            sa = 1; sb = 2; alu = 4'(i_alu(o));
            ext = !(o == 6'b001100 || o == 6'b001101 || o == 6'b001111);
         end
         StExMa: begin sa = 1; sb = 2; end
         StExBr: begin
            sa = 1; alu = 1; ps = 1; peq = (o == 6'b000100); pne = (o == 6'b000101);
         end
         StExJ:   begin ps = 2; pw = 1; end
         StMemRd: begin io = 1; mr = 1; end
         StMemWr: begin io = 1; mw = 1; end
         StWbR:   begin rw = 1; rd = 1; end
         StWbI:   rw = 1;
         StWbMem: begin rw = 1; m2r = 1; end
         default: ;
      endcase
      return {pw, peq, pne, ps, irw, io, mr, mw, rw, rd, m2r, sa, sb, alu, ext, sh, ill};
   endfunction

   // Runs max_steps phases of the instruction (all when negative); entry is just after a
   // rising edge with the DUT in IF.
   task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int max_steps);
      mcc_state_e seq[$];
      logic held;
      int stalls;
      op   = o;
      func = f;
      build_seq(o, f, seq);
      foreach (seq[i]) begin
         if (max_steps >= 0 && i >= max_steps) break;
         stalls = 0;
         do begin
`ifdef MCC_STALL_EN
            mem_ready = (stalls >= 6) ? 1'b1 : ($urandom_range(0, 2) != 0);
`endif
            @(negedge clk);
            check_val("state", 32'(state), 32'(seq[i]));
            check_val("outs", 32'(obs), 32'(exp_outs(seq[i], o, f, mem_ready)));
            held = (seq[i] inside {StIf, StMemRd, StMemWr}) && !mem_ready;
            stalls++;
            @(posedge clk);
            #1;
         end while (held);
      end
   endtask

   logic [5:0] legal_ops [12] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                                  6'b000010, 6'b001000, 6'b001001, 6'b001010, 6'b001100,
                                  6'b001101, 6'b001111};
   logic [5:0] legal_fns [13] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
                                  6'b100101, 6'b100110, 6'b100111, 6'b101010, 6'b101011,
                                  6'b000000, 6'b000010, 6'b000011};

   initial begin
      logic [5:0] ro, rf;
      rst       = 1'b1;
      op        = 6'b000000;
      func      = 6'b100000;
      mem_ready = 1'b1;
      #2;
      check_val("rst_state", 32'(state), 32'(StIf));
      check_val("rst_wr", {28'd0, pc_wr, ir_wr, reg_wr, illegal}, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;

      run_instr(6'b100011, 6'b000000, -1); // lw
      run_instr(6'b000000, 6'b100000, -1); // add
      run_instr(6'b000000, 6'b000000, -1); // sll
      run_instr(6'b000100, 6'b000000, -1); // beq
      run_instr(6'b000101, 6'b000000, -1); // bne
      run_instr(6'b111111, 6'b000000, -1); // illegal op
      run_instr(6'b000000, 6'b111111, -1); // illegal func
      run_instr(6'b001101, 6'b000000, -1); // ori
      run_instr(6'b000010, 6'b000000, -1); // j

      // sw interrupted by reset while in MEM_WR
      run_instr(6'b101011, 6'b000000, 3);
      mem_ready = 1'b1;
      @(negedge clk);
      check_val("sw_memwr", 32'(mem_wr), 32'd1);
      #1 rst = 1'b1;
      #1;
      check_val("rst_mid_memwr", 32'(mem_wr), 32'd0);
      check_val("rst_mid_state", 32'(state), 32'(StIf));
      check_val("rst_mid_strobes", {28'd0, pc_wr, ir_wr, reg_wr, illegal}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      run_instr(6'b100011, 6'b000000, -1);

      for (int n = 0; n < 300; n++) begin
         ro = ($urandom_range(0, 5) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 11)];
         rf = ($urandom_range(0, 5) == 0) ? 6'($urandom) : legal_fns[$urandom_range(0, 12)];
         run_instr(ro, rf, -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
